// File: rtl/lbist_pkg.sv
// Shared LBIST constants and the ORA state encoding also used by the BIST controller.
package lbist_pkg;

    localparam logic [31:0] LBIST_POLY    = 32'h04C11DB7;
    localparam logic [31:0] LBIST_SEED    = 32'hFFFFFFFF;
    localparam int unsigned LBIST_N_RESP  = 8;
    localparam int unsigned LBIST_TIMEOUT = 64;

    typedef logic [1:0] ora_state_t;

    localparam ora_state_t ORA_IDLE    = 2'd0;
    localparam ora_state_t ORA_COMPACT = 2'd1;
    localparam ora_state_t ORA_COMPARE = 2'd2;
    localparam ora_state_t ORA_DONE    = 2'd3;

endpackage

// File: rtl/lbist_ora_if.sv
// Store-snoop and result bus between the BIST controller/core side and the ORA.
interface lbist_ora_if;

    logic        test_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] golden;
    logic [31:0] signature;
    logic [3:0]  resp_cnt;
    logic        done;
    logic        pass;
    logic        timeout;
    logic        overrun;

    modport master (
        output test_en, mem_we, mem_addr, mem_wdata, golden,
        input  signature, resp_cnt, done, pass, timeout, overrun
    );

    modport slave (
        input  test_en, mem_we, mem_addr, mem_wdata, golden,
        output signature, resp_cnt, done, pass, timeout, overrun
    );

endinterface

// File: rtl/lbist_misr.sv
// 32-bit multiple-input signature register; seed load has priority over a step.
module lbist_misr
    import lbist_pkg::*;
#(
    parameter logic [31:0] POLY = LBIST_POLY,
    parameter logic [31:0] SEED = LBIST_SEED
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        load_seed,
    input  logic        step,
    input  logic [31:0] data_in,
    output logic [31:0] sig
);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sig <= SEED;
        end else if (load_seed) begin
            sig <= SEED;
        end else if (step) begin
            sig <= {sig[30:0], 1'b0} ^ (sig[31] ? POLY : '0) ^ data_in;
        end
    end

endmodule

// File: rtl/lbist_ora.sv
// LBIST output response analyser: snoops data-memory stores, compacts them into
// a MISR signature and reports done/pass against a golden value.
module lbist_ora
    import lbist_pkg::*;
#(
    parameter int unsigned N_RESP  = LBIST_N_RESP,
    parameter logic [31:0] POLY    = LBIST_POLY,
    parameter logic [31:0] SEED    = LBIST_SEED,
    parameter int unsigned TIMEOUT = LBIST_TIMEOUT
) (
    input  logic        clk,
    input  logic        nRst,
    lbist_ora_if.slave  bus
);

    localparam int unsigned TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]  CNT_FULL = 4'(N_RESP);
    localparam logic [3:0]  CNT_LAST = 4'(N_RESP - 1);
    localparam logic [31:0] ADDR_LIM = 32'(4 * N_RESP);

    ora_state_t    state;
    logic [3:0]    resp_cnt;
    logic [TW-1:0] timer;
    logic          done;
    logic          pass;
    logic          timeout;
    logic          overrun;
    logic [31:0]   sig;
    logic          accept;
    logic          load_seed;
    logic          misr_step;

    assign accept    = bus.mem_we && (bus.mem_addr[1:0] == 2'b00) && (bus.mem_addr < ADDR_LIM);
    assign load_seed = !bus.test_en || (state == ORA_IDLE);
    assign misr_step = accept && (state == ORA_COMPACT);

    lbist_misr #(
        .POLY (POLY),
        .SEED (SEED)
    ) u_misr (
        .clk       (clk),
        .nRst      (nRst),
        .load_seed (load_seed),
        .step      (misr_step),
        .data_in   (bus.mem_wdata),
        .sig       (sig)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state    <= ORA_IDLE;
            resp_cnt <= '0;
            timer    <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            overrun  <= 1'b0;
        end else if (!bus.test_en) begin
            state    <= ORA_IDLE;
            resp_cnt <= '0;
            timer    <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            case (state)
                ORA_IDLE: begin
                    state <= ORA_COMPACT;
                end
                ORA_COMPACT: begin
                    if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                    if (accept && resp_cnt != CNT_FULL) begin
                        resp_cnt <= resp_cnt + 1'b1;
                    end
                    // Completing the run wins over a timeout landing on the same edge.
                    if (accept && resp_cnt == CNT_LAST) begin
                        state <= ORA_COMPARE;
                    end else if (timer == T_LAST) begin
                        state   <= ORA_DONE;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                ORA_COMPARE: begin
                    state <= ORA_DONE;
                    done  <= 1'b1;
                    pass  <= (sig == bus.golden) && !overrun && !accept;
                    if (accept) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        overrun <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.signature = sig;
    assign bus.resp_cnt  = resp_cnt;
    assign bus.done      = done;
    assign bus.pass      = pass;
    assign bus.timeout   = timeout;
    assign bus.overrun   = overrun;

endmodule

// File: tb/tb_lbist_ora.sv
// Directed self-checking bench for lbist_ora.
module tb_lbist_ora;

    logic clk;
    logic nRst;
    int   nvec;
    int   nfail;
    logic [31:0] gold8;

    lbist_ora_if bus();

    lbist_ora dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] s, input logic [31:0] d);
        logic [31:0] r;
        r = {s[30:0], 1'b0} ^ d;
        if (s[31]) r = r ^ 32'h04C11DB7;
        return r;
    endfunction

    // One clock: inputs applied, edge taken, outputs sampled 1 time unit later.
    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.mem_we    = we;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        @(posedge clk);
        #1;
        bus.mem_we = 1'b0;
    endtask

    task automatic arm();
        bus.test_en = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
    endtask

    task automatic disarm();
        bus.test_en = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
    endtask

    task automatic run8(input logic [31:0] g);
        bus.golden = g;
        arm();
        for (int i = 0; i < 8; i++) drive(1'b1, 32'(4 * i), 32'(i + 1));
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        bus.test_en = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.golden = '0;
        #12;
        nvec++; if (bus.signature !== 32'hFFFFFFFF) begin nfail++; $display("FAIL reset_sig got=%h exp=%h", bus.signature, 32'hFFFFFFFF); end
        nvec++; if (bus.resp_cnt !== 4'd0) begin nfail++; $display("FAIL reset_cnt got=%0d exp=0", bus.resp_cnt); end
        nvec++; if ({bus.done, bus.pass, bus.timeout, bus.overrun} !== 4'b0000) begin nfail++;
            $display("FAIL reset_flags got=%b exp=0000", {bus.done, bus.pass, bus.timeout, bus.overrun}); end
        @(negedge clk);
        nRst = 1'b1;
        arm();
        drive(1'b1, 32'h0, 32'h0);
        nvec++; if (bus.signature !== 32'hFB3EE249) begin nfail++; $display("FAIL first_sig got=%h exp=FB3EE249", bus.signature); end
        nvec++; if (bus.resp_cnt !== 4'd1) begin nfail++; $display("FAIL first_cnt got=%0d exp=1", bus.resp_cnt); end
        nvec++; if (bus.done !== 1'b0) begin nfail++; $display("FAIL first_done got=%b exp=0", bus.done); end
        disarm();
    endtask

    task automatic test_compact();
        run8(gold8);
        nvec++; if (bus.signature !== gold8) begin nfail++; $display("FAIL c8_sig got=%h exp=%h", bus.signature, gold8); end
        nvec++; if (bus.resp_cnt !== 4'd8) begin nfail++; $display("FAIL c8_cnt got=%0d exp=8", bus.resp_cnt); end
        nvec++; if (bus.done !== 1'b0) begin nfail++; $display("FAIL c8_done_early got=%b exp=0", bus.done); end
        drive(1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 32'h0);
        nvec++; if ({bus.done, bus.pass, bus.timeout, bus.overrun} !== 4'b1100) begin nfail++;
            $display("FAIL c8_result got=%b exp=1100", {bus.done, bus.pass, bus.timeout, bus.overrun}); end
        disarm();
        run8(gold8 ^ 32'h0000_0100);
        drive(1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 32'h0);
        nvec++; if ({bus.done, bus.pass} !== 2'b10) begin nfail++;
            $display("FAIL c8_badgold got=%b exp=10", {bus.done, bus.pass}); end
        disarm();
    endtask

    task automatic test_filter();
        logic        we[8];
        logic [31:0] ad[8];
        logic [31:0] s;
        logic [3:0]  c;
        we = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        ad = '{32'h0, 32'h20, 32'h4, 32'h2, 32'h8, 32'h8, 32'hFFFF_FFFC, 32'h1D};
        s = 32'hFFFFFFFF;
        c = 4'd0;
        bus.golden = '0;
        arm();
        for (int i = 0; i < 8; i++) begin
            drive(we[i], ad[i], 32'hA5A5_0000 + 32'(i * 77));
            if (we[i] && ad[i][1:0] == 2'b00 && ad[i] < 32'd32) begin
                s = model(s, 32'hA5A5_0000 + 32'(i * 77));
                c = c + 4'd1;
            end
            nvec++; if (bus.signature !== s) begin nfail++; $display("FAIL filt_sig[%0d] got=%h exp=%h", i, bus.signature, s); end
            nvec++; if (bus.resp_cnt !== c) begin nfail++; $display("FAIL filt_cnt[%0d] got=%0d exp=%0d", i, bus.resp_cnt, c); end
        end
        disarm();
    endtask

    task automatic test_timeout();
        logic [31:0] s;
        s = 32'hFFFFFFFF;
        bus.golden = '0;
        arm();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(4 * i), 32'(i + 1));
            s = model(s, 32'(i + 1));
        end
        for (int i = 0; i < 58; i++) drive(1'b0, 32'h0, 32'h0);
        nvec++; if ({bus.done, bus.timeout} !== 2'b00) begin nfail++;
            $display("FAIL to_early got=%b exp=00", {bus.done, bus.timeout}); end
        drive(1'b0, 32'h0, 32'h0);
        nvec++; if ({bus.done, bus.pass, bus.timeout, bus.overrun} !== 4'b1010) begin nfail++;
            $display("FAIL to_flags got=%b exp=1010", {bus.done, bus.pass, bus.timeout, bus.overrun}); end
        nvec++; if (bus.resp_cnt !== 4'd5) begin nfail++; $display("FAIL to_cnt got=%0d exp=5", bus.resp_cnt); end
        nvec++; if (bus.signature !== s) begin nfail++; $display("FAIL to_sig got=%h exp=%h", bus.signature, s); end
        disarm();
    endtask

    task automatic test_overrun();
        run8(gold8);
        drive(1'b0, 32'h0, 32'h0);
        nvec++; if (bus.pass !== 1'b1) begin nfail++; $display("FAIL ov_prepass got=%b exp=1", bus.pass); end
        drive(1'b1, 32'h0, 32'hDEAD_BEEF);
        nvec++; if ({bus.done, bus.pass, bus.overrun} !== 3'b101) begin nfail++;
            $display("FAIL ov_flags got=%b exp=101", {bus.done, bus.pass, bus.overrun}); end
        nvec++; if (bus.signature !== gold8) begin nfail++; $display("FAIL ov_sig got=%h exp=%h", bus.signature, gold8); end
        nvec++; if (bus.resp_cnt !== 4'd8) begin nfail++; $display("FAIL ov_cnt got=%0d exp=8", bus.resp_cnt); end
        disarm();
        run8(gold8);
        drive(1'b1, 32'h4, 32'h1234_5678);
        nvec++; if ({bus.done, bus.pass, bus.overrun} !== 3'b101) begin nfail++;
            $display("FAIL ov_cmp_flags got=%b exp=101", {bus.done, bus.pass, bus.overrun}); end
        nvec++; if (bus.signature !== gold8) begin nfail++; $display("FAIL ov_cmp_sig got=%h exp=%h", bus.signature, gold8); end
        disarm();
    endtask

    task automatic test_abort();
        bus.golden = gold8;
        arm();
        for (int i = 0; i < 4; i++) drive(1'b1, 32'(4 * i), 32'(i + 1));
        disarm();
        nvec++; if (bus.signature !== 32'hFFFFFFFF || bus.resp_cnt !== 4'd0) begin nfail++;
            $display("FAIL ab_drop got=%h/%0d exp=ffffffff/0", bus.signature, bus.resp_cnt); end
        run8(gold8);
        drive(1'b0, 32'h0, 32'h0);
        nvec++; if ({bus.done, bus.pass} !== 2'b11) begin nfail++; $display("FAIL ab_drop_rerun got=%b exp=11", {bus.done, bus.pass}); end
        disarm();

        arm();
        for (int i = 0; i < 4; i++) drive(1'b1, 32'(4 * i), 32'(i + 1));
        bus.test_en = 1'b0;
        #2 nRst = 1'b0;
        #1;
        nvec++; if (bus.signature !== 32'hFFFFFFFF || bus.resp_cnt !== 4'd0 ||
                    {bus.done, bus.pass, bus.timeout, bus.overrun} !== 4'b0000) begin nfail++;
            $display("FAIL ab_rst got=%h/%0d/%b exp=ffffffff/0/0000", bus.signature, bus.resp_cnt,
                     {bus.done, bus.pass, bus.timeout, bus.overrun}); end
        nRst = 1'b1;
        run8(gold8);
        drive(1'b0, 32'h0, 32'h0);
        nvec++; if ({bus.done, bus.pass} !== 2'b11) begin nfail++; $display("FAIL ab_rst_rerun got=%b exp=11", {bus.done, bus.pass}); end
        disarm();

        arm();
        for (int i = 0; i < 3; i++) drive(1'b1, 32'(4 * i), 32'(i + 1));
        bus.test_en = 1'b0;
        drive(1'b1, 32'hC, 32'h4);
        nvec++; if (bus.signature !== 32'hFFFFFFFF || bus.resp_cnt !== 4'd0) begin nfail++;
            $display("FAIL ab_same got=%h/%0d exp=ffffffff/0", bus.signature, bus.resp_cnt); end
        run8(gold8);
        drive(1'b0, 32'h0, 32'h0);
        nvec++; if ({bus.done, bus.pass} !== 2'b11) begin nfail++; $display("FAIL ab_same_rerun got=%b exp=11", {bus.done, bus.pass}); end
        disarm();
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        gold8 = 32'hFFFFFFFF;
        for (int i = 0; i < 8; i++) gold8 = model(gold8, 32'(i + 1));
        test_reset();
        test_compact();
        test_filter();
        test_timeout();
        test_overrun();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
